// File: rtl/cache_test_monitor.sv
// Pass/fail monitor for NUM_CH cache self-test channels: first-failure capture, index tracking, stall watchdog.
// Optional order check enabled by defining CACHE_MON_SEQ_CHECK_EN; all outputs registered (latency 1).
module cache_test_monitor #(
  parameter int NUM_CH         = 2,
  parameter int INDEX_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WD_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             round_finish,
  input  logic [NUM_CH-1:0]             replace_wrong,
  input  logic [NUM_CH-1:0]             cacheres_wrong,
  input  logic [NUM_CH*INDEX_WIDTH-1:0] test_index,
  output logic [NUM_CH-1:0]             ch_done,
  output logic                          done,
  output logic                          pass,
  output logic                          fail,
  output logic [2:0]                    fail_code,
  output logic [CH_W-1:0]               fail_ch,
  output logic [INDEX_WIDTH-1:0]        fail_index
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PASS = 2'd1,
    S_FAIL = 2'd2
  } state_e;

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_REPLACE  = 3'd1;
  localparam logic [2:0] CODE_CACHERES = 3'd2;
  localparam logic [2:0] CODE_TIMEOUT  = 3'd3;
`ifdef CACHE_MON_SEQ_CHECK_EN
  localparam logic [2:0] CODE_SEQ      = 3'd4;
`endif

  state_e                               state_q, state_d;
  logic [NUM_CH-1:0]                    ch_done_q, ch_done_d;
  logic [NUM_CH-1:0][INDEX_WIDTH-1:0]   exp_q, exp_d;
  logic [WD_W-1:0]                      wd_q, wd_d;
  logic [2:0]                           fail_code_q, fail_code_d;
  logic [CH_W-1:0]                      fail_ch_q, fail_ch_d;
  logic [INDEX_WIDTH-1:0]               fail_index_q, fail_index_d;

  always_comb begin
    logic [INDEX_WIDTH-1:0] idx;
    logic [2:0]             code;
    logic                   err_found;
    logic                   any_rf;

    state_d      = state_q;
    ch_done_d    = ch_done_q;
    exp_d        = exp_q;
    wd_d         = wd_q;
    fail_code_d  = fail_code_q;
    fail_ch_d    = fail_ch_q;
    fail_index_d = fail_index_q;
    idx          = '0;
    code         = CODE_NONE;
    err_found    = 1'b0;
    any_rf       = 1'b0;

    if (state_q == S_RUN) begin
      // Ascending scan so the lowest failing channel is the one captured.
      for (int c = 0; c < NUM_CH; c++) begin
        idx  = test_index[c*INDEX_WIDTH +: INDEX_WIDTH];
        code = CODE_NONE;
        if (!ch_done_q[c]) begin
          if (round_finish[c]) begin
            any_rf = 1'b1;
            if (idx == exp_q[c]) begin
              if (&idx) ch_done_d[c] = 1'b1;
              else      exp_d[c]     = exp_q[c] + INDEX_WIDTH'(1);
            end else begin
`ifdef CACHE_MON_SEQ_CHECK_EN
              code = CODE_SEQ;
`else
              if (&idx) ch_done_d[c] = 1'b1;
`endif
            end
          end else if (replace_wrong[c]) begin
            code = CODE_REPLACE;
          end else if (cacheres_wrong[c]) begin
            code = CODE_CACHERES;
          end
        end
        if (code != CODE_NONE && !err_found) begin
          err_found    = 1'b1;
          fail_code_d  = code;
          fail_ch_d    = CH_W'(c);
          fail_index_d = idx;
        end
      end

      if (any_rf)                      wd_d = '0;
      else if (wd_q != {WD_W{1'b1}})   wd_d = wd_q + WD_W'(1);

      // Channel errors take precedence over a coincident timeout, and any failure over pass.
      if (err_found) begin
        state_d = S_FAIL;
      end else if (!any_rf && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        state_d      = S_FAIL;
        fail_code_d  = CODE_TIMEOUT;
        fail_ch_d    = '0;
        fail_index_d = '0;
      end else if (&ch_done_d) begin
        state_d = S_PASS;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RUN;
      ch_done_q    <= '0;
      exp_q        <= '0;
      wd_q         <= '0;
      fail_code_q  <= CODE_NONE;
      fail_ch_q    <= '0;
      fail_index_q <= '0;
    end else begin
      state_q      <= state_d;
      ch_done_q    <= ch_done_d;
      exp_q        <= exp_d;
      wd_q         <= wd_d;
      fail_code_q  <= fail_code_d;
      fail_ch_q    <= fail_ch_d;
      fail_index_q <= fail_index_d;
    end
  end

  assign ch_done    = ch_done_q;
  assign pass       = (state_q == S_PASS);
  assign fail       = (state_q == S_FAIL);
  assign done       = pass | fail;
  assign fail_code  = fail_code_q;
  assign fail_ch    = fail_ch_q;
  assign fail_index = fail_index_q;

endmodule

// File: tb/tb_cache_test_monitor.sv
// Bench for cache_test_monitor: directed scenarios plus random traffic against a per-cycle reference model.
module tb_cache_test_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] round_finish, replace_wrong, cacheres_wrong;
  logic [3:0] test_index;
  logic [1:0] ch_done;
  logic       done, pass, fail;
  logic [2:0] fail_code;
  logic [0:0] fail_ch;
  logic [1:0] fail_index;

  int n_err = 0;
  int n_chk = 0;

  // Reference model state: 0 running, 1 passed, 2 failed.
  int m_exp[2];
  bit m_dn[2];
  int m_st, m_code, m_ch, m_idx, m_idle;

  cache_test_monitor #(.NUM_CH(2), .INDEX_WIDTH(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .round_finish(round_finish), .replace_wrong(replace_wrong), .cacheres_wrong(cacheres_wrong),
    .test_index(test_index),
    .ch_done(ch_done), .done(done), .pass(pass), .fail(fail),
    .fail_code(fail_code), .fail_ch(fail_ch), .fail_index(fail_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int  ix[2];
    bit  found, any_rf;
    int  fc, fch, fix;
    if (reset) begin
      m_exp[0] = 0; m_exp[1] = 0; m_dn[0] = 0; m_dn[1] = 0;
      m_st = 0; m_code = 0; m_ch = 0; m_idx = 0; m_idle = 0;
      return;
    end
    if (m_st != 0) return;
    found = 0; any_rf = 0; fc = 0; fch = 0; fix = 0;
    for (int c = 0; c < 2; c++) begin
      ix[c] = int'(test_index[c*2 +: 2]);
      if (!m_dn[c]) begin
        if (round_finish[c]) begin
          any_rf = 1;
          if (ix[c] == m_exp[c]) begin
            if (ix[c] == 3) m_dn[c] = 1;
            else            m_exp[c]++;
          end else begin
`ifdef CACHE_MON_SEQ_CHECK_EN
            if (!found) begin found = 1; fc = 4; fch = c; fix = ix[c]; end
`else
            if (ix[c] == 3) m_dn[c] = 1;
`endif
          end
        end else if (replace_wrong[c]) begin
          if (!found) begin found = 1; fc = 1; fch = c; fix = ix[c]; end
        end else if (cacheres_wrong[c]) begin
          if (!found) begin found = 1; fc = 2; fch = c; fix = ix[c]; end
        end
      end
    end
    m_idle = any_rf ? 0 : m_idle + 1;
    if (found) begin
      m_st = 2; m_code = fc; m_ch = fch; m_idx = fix;
    end else if (m_idle >= 16) begin
      m_st = 2; m_code = 3; m_ch = 0; m_idx = 0;
    end else if (m_dn[0] && m_dn[1]) begin
      m_st = 1;
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = {21'd0, m_dn[1], m_dn[0], (m_st != 0), (m_st == 1), (m_st == 2),
         m_code[2:0], m_ch[0], m_idx[1:0]};
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("status", {21'd0, ch_done, done, pass, fail, fail_code, fail_ch, fail_index}, model_status());
  endtask

  task automatic drive(input logic [1:0] rf, input logic [1:0] rw, input logic [1:0] cw,
                       input logic [1:0] i0, input logic [1:0] i1);
    round_finish = rf; replace_wrong = rw; cacheres_wrong = cw; test_index = {i1, i0};
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 2'd0, 2'd0);
    reset = 1'b0;
  endtask

  task automatic full_pass();
    for (int i = 0; i < 4; i++) drive(2'b11, 2'b00, 2'b00, 2'(i), 2'(i));
  endtask

  initial begin
    reset = 1'b1; round_finish = '0; replace_wrong = '0; cacheres_wrong = '0; test_index = '0;
    do_reset();
    check("reset_outputs", {21'd0, ch_done, done, pass, fail, fail_code, fail_ch, fail_index}, 32'd0);

    // Both channels walk 0..3 in order.
    full_pass();
    check("t1_ch_done", ch_done, 2'b11);
    check("t1_pass", pass, 1);
    check("t1_fail", fail, 0);
    check("t1_code", fail_code, 0);

    // Simultaneous errors: channel 0 wins even with the lower-ranked cause.
    do_reset();
    drive(2'b11, 2'b00, 2'b00, 2'd0, 2'd0);
    drive(2'b11, 2'b00, 2'b00, 2'd1, 2'd1);
    drive(2'b00, 2'b10, 2'b01, 2'd2, 2'd2);
    check("t2_fail", fail, 1);
    check("t2_code", fail_code, 2);
    check("t2_ch", fail_ch, 0);
    check("t2_index", fail_index, 2);

    // round_finish masks a same-cycle replace error and still advances.
    do_reset();
    drive(2'b01, 2'b01, 2'b00, 2'd0, 2'd0);
    check("t3_nofail", fail, 0);
    drive(2'b01, 2'b00, 2'b00, 2'd1, 2'd0);
    check("t3_advanced", fail, 0);

    // Watchdog: silence right after reset.
    do_reset();
    for (int i = 0; i < 15; i++) drive(2'b00, 2'b00, 2'b00, 2'd0, 2'd0);
    check("t4_before", fail, 0);
    drive(2'b00, 2'b00, 2'b00, 2'd0, 2'd0);
    check("t4_fail", fail, 1);
    check("t4_code", fail_code, 3);
    check("t4_pass", pass, 0);

    // Out-of-order index on channel 1.
    do_reset();
    drive(2'b10, 2'b00, 2'b00, 2'd0, 2'd0);
    drive(2'b10, 2'b00, 2'b00, 2'd0, 2'd2);
`ifdef CACHE_MON_SEQ_CHECK_EN
    check("t5_code", fail_code, 4);
    check("t5_ch", fail_ch, 1);
    check("t5_index", fail_index, 2);
`else
    check("t5_nofail", fail, 0);
`endif

    // Reset mid-run after a failure, then a clean pass.
    do_reset();
    for (int i = 0; i < 16; i++) drive(2'b00, 2'b00, 2'b00, 2'd0, 2'd0);
    check("t6_failed", fail, 1);
    do_reset();
    check("t6_cleared", {21'd0, ch_done, done, pass, fail, fail_code, fail_ch, fail_index}, 32'd0);
    full_pass();
    check("t6_pass", pass, 1);

    // Random traffic; index mostly follows the expected sequence.
    for (int run = 0; run < 12; run++) begin
      int rf_mod;
      rf_mod = 2 + int'($urandom_range(0, 6));
      do_reset();
      for (int cyc = 0; cyc < 120; cyc++) begin
        logic [1:0] rf, rw, cw, ix0, ix1;
        for (int c = 0; c < 2; c++) begin
          rf[c] = ($urandom % rf_mod) == 0;
          rw[c] = ($urandom % 30) == 0;
          cw[c] = ($urandom % 30) == 0;
        end
        ix0 = (($urandom % 10) == 0) ? 2'($urandom) : 2'(m_exp[0]);
        ix1 = (($urandom % 10) == 0) ? 2'($urandom) : 2'(m_exp[1]);
        reset = (($urandom % 150) == 0);
        drive(rf, rw, cw, ix0, ix1);
        reset = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
